// File: rtl/hr_interval_averager_if.sv
// Beat-interval averager port bundle: sample/peak inputs in,
// smoothed heart-rate and status outputs back.
interface hr_interval_averager_if #(
    parameter int CNT_W = 11
);
    logic             sample_tick;
    logic             peak;
    logic [7:0]       bpm;
    logic             bpm_valid;
    logic             locked;
    logic             beat_rejected;
    logic [CNT_W-1:0] interval;

    modport master (
        output sample_tick, peak,
        input  bpm, bpm_valid, locked, beat_rejected, interval
    );

    modport slave (
        input  sample_tick, peak,
        output bpm, bpm_valid, locked, beat_rejected, interval
    );
endinterface

// File: rtl/hr_interval_averager.sv
// Beat-to-beat interval averager: validates peak intervals, keeps a
// window of accepted intervals and divides them into a smoothed BPM.
module hr_interval_averager #(
    parameter int FS_HZ        = 100,
    parameter int MIN_INTERVAL = 30,
    parameter int MAX_INTERVAL = 300,
    parameter int AVG_LOG2     = 2,
    parameter int CNT_W        = 11
) (
    input logic             clock,
    input logic             reset,
    hr_interval_averager_if.slave bus
);
    localparam int N      = 1 << AVG_LOG2;
    localparam int SUM_W  = CNT_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam logic [15:0] K = 16'(60 * FS_HZ);

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        UPDATE,
        DIVIDE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                peak_q, peak_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [CNT_W-1:0]    pend_iv_q, pend_iv_d;
    logic [CNT_W-1:0]    cap_q, cap_d;
    logic [CNT_W-1:0]    hist_q [N];
    logic [CNT_W-1:0]    hist_d [N];
    logic [AVG_LOG2-1:0] wp_q, wp_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [15:0]         num_q, num_d;
    logic [SUM_W-1:0]    rem_q, rem_d;
    logic [SUM_W-1:0]    den_q, den_d;
    logic [3:0]          step_q, step_d;
    logic [7:0]          bpm_q, bpm_d;
    logic                bpm_valid_q, bpm_valid_d;
    logic                locked_q, locked_d;
    logic                rej_q, rej_d;
    logic [CNT_W-1:0]    interval_q, interval_d;

    logic                beat;
    logic                ev;
    logic                timeout;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    ev_iv;
    logic [SUM_W-1:0]    evict;
    logic [SUM_W-1:0]    sum_nx;
    logic [FILL_W-1:0]   fill_nx;
    logic [SUM_W:0]      trial;
    logic [SUM_W-1:0]    diff;

    always_comb begin
        state_d     = state_q;
        peak_d      = bus.peak;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_iv_d   = pend_iv_q;
        cap_d       = cap_q;
        hist_d      = hist_q;
        wp_d        = wp_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        num_d       = num_q;
        rem_d       = rem_q;
        den_d       = den_q;
        step_d      = step_q;
        bpm_d       = bpm_q;
        bpm_valid_d = 1'b0;
        locked_d    = locked_q;
        rej_d       = 1'b0;
        interval_d  = interval_q;

        beat    = bus.peak & ~peak_q;
        cnt_inc = cnt_q + CNT_W'(bus.sample_tick);
        timeout = cnt_inc > CNT_W'(MAX_INTERVAL);
        // A beat latched while busy is serviced ahead of any live edge
        ev      = pend_q | beat;
        ev_iv   = pend_q ? pend_iv_q : cnt_inc;
        evict   = (fill_q == FILL_W'(N)) ? SUM_W'(hist_q[wp_q]) : '0;
        sum_nx  = sum_q - evict + SUM_W'(cap_q);
        fill_nx = (fill_q == FILL_W'(N)) ? fill_q : fill_q + 1'b1;
        trial   = {rem_q, num_q[15]};
        diff    = trial[SUM_W-1:0] - den_q;

        if (state_q inside {UPDATE, DIVIDE, DONE}) begin
            cnt_d = cnt_inc;
            if (beat && !pend_q) begin
                pend_d    = 1'b1;
                pend_iv_d = cnt_inc;
            end
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (beat) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                cnt_d  = cnt_inc;
                pend_d = 1'b0;
                if (timeout) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    for (int i = 0; i < N; i++) begin
                        hist_d[i] = '0;
                    end
                    wp_d     = '0;
                    sum_d    = '0;
                    fill_d   = '0;
                    bpm_d    = '0;
                    locked_d = 1'b0;
                end else if (ev) begin
                    if (ev_iv < CNT_W'(MIN_INTERVAL)) begin
                        rej_d = 1'b1;
                    end else begin
                        cap_d   = ev_iv;
                        cnt_d   = '0;
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                hist_d[wp_q] = cap_q;
                wp_d         = wp_q + AVG_LOG2'(1);
                sum_d        = sum_nx;
                fill_d       = fill_nx;
                locked_d     = fill_nx == FILL_W'(N);
                interval_d   = cap_q;
                num_d        = K * 16'(fill_nx);
                den_d        = sum_nx;
                rem_d        = '0;
                step_d       = '0;
                state_d      = DIVIDE;
            end
            DIVIDE: begin
                // Restoring step; quotient bits shift into num from the LSB
                if (trial >= {1'b0, den_q}) begin
                    rem_d = diff;
                    num_d = {num_q[14:0], 1'b1};
                end else begin
                    rem_d = trial[SUM_W-1:0];
                    num_d = {num_q[14:0], 1'b0};
                end
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bpm_d       = (|num_q[15:8]) ? 8'hff : num_q[7:0];
                bpm_valid_d = 1'b1;
                state_d     = MEASURE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            peak_q      <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_iv_q   <= '0;
            cap_q       <= '0;
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= '0;
            end
            wp_q        <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            num_q       <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            step_q      <= '0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            rej_q       <= 1'b0;
            interval_q  <= '0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_iv_q   <= pend_iv_d;
            cap_q       <= cap_d;
            hist_q      <= hist_d;
            wp_q        <= wp_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            num_q       <= num_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            step_q      <= step_d;
            bpm_q       <= bpm_d;
            bpm_valid_q <= bpm_valid_d;
            locked_q    <= locked_d;
            rej_q       <= rej_d;
            interval_q  <= interval_d;
        end
    end

    assign bus.bpm           = bpm_q;
    assign bus.bpm_valid     = bpm_valid_q;
    assign bus.locked        = locked_q;
    assign bus.beat_rejected = rej_q;
    assign bus.interval      = interval_q;
endmodule

// File: tb/tb_hr_interval_averager.sv
// Bench for hr_interval_averager: directed beat patterns plus random
// intervals, compared every cycle against an interval-window model.
module tb_hr_interval_averager;
    localparam int MIN_IV  = 30;
    localparam int MAX_IV  = 300;
    localparam int LATENCY = 18;

    logic clock = 1'b0;
    logic reset = 1'b1;

    hr_interval_averager_if ifc ();

    hr_interval_averager dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rej_seen = 0;

    // Reference model state: window of accepted intervals, ticks since
    // the last accepted beat, and the time each result becomes visible.
    bit armed, pend, prev_pk;
    int since, piv, busy;
    int win[$];
    int upd_at, upd_iv, upd_lk;
    int val_at, val_bpm, rej_at;
    int exp_bpm, exp_lock, exp_iv;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic void model(bit rst, bit pk, bit tk);
        bit rise;
        int inc, iv, s;
        if (rst) begin
            armed = 0; pend = 0; prev_pk = 0;
            since = 0; busy = 0;
            win.delete();
            upd_at = -1; val_at = -1; rej_at = -1;
            exp_bpm = 0; exp_lock = 0; exp_iv = 0;
            return;
        end
        rise = pk && !prev_pk;
        prev_pk = pk;
        inc = since + int'(tk);
        if (!armed) begin
            since = 0;
            if (rise) armed = 1;
        end else if (busy > 0) begin
            busy--;
            since = inc;
            if (rise && !pend) begin
                pend = 1;
                piv = inc;
            end
        end else if (inc > MAX_IV) begin
            armed = 0; since = 0; pend = 0;
            win.delete();
            exp_bpm = 0;
            exp_lock = 0;
        end else if (rise || pend) begin
            iv = pend ? piv : inc;
            pend = 0;
            if (iv < MIN_IV) begin
                rej_at = cyc;
                since = inc;
            end else begin
                win.push_back(iv);
                if (win.size() > 4) void'(win.pop_front());
                s = win.sum();
                since = 0;
                busy = LATENCY;
                upd_at = cyc + 1;
                upd_iv = iv;
                upd_lk = int'(win.size() == 4);
                val_at = cyc + LATENCY;
                val_bpm = (6000 * win.size()) / s;
                if (val_bpm > 255) val_bpm = 255;
            end
        end else begin
            since = inc;
        end
    endfunction

    task automatic step(bit rst, bit pk, bit tk);
        @(negedge clock);
        reset = rst;
        ifc.peak = pk;
        ifc.sample_tick = tk;
        model(rst, pk, tk);
        @(posedge clock);
        #1;
        if (cyc == upd_at) begin
            exp_iv = upd_iv;
            exp_lock = upd_lk;
        end
        if (cyc == val_at) exp_bpm = val_bpm;
        if (ifc.beat_rejected === 1'b1) rej_seen++;
        check("bpm_valid", 32'(ifc.bpm_valid), 32'(cyc == val_at));
        check("beat_rejected", 32'(ifc.beat_rejected), 32'(cyc == rej_at));
        check("bpm", 32'(ifc.bpm), 32'(exp_bpm));
        check("locked", 32'(ifc.locked), 32'(exp_lock));
        check("interval", 32'(ifc.interval), 32'(exp_iv));
        cyc++;
    endtask

    task automatic quiet(int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    // Peak edge lands on the gap-th tick after the previous beat
    task automatic beat(int gap, int hold = 1, int idle_max = 1);
        repeat (gap - 1) begin
            repeat ($urandom_range(idle_max, 0)) step(0, 0, 0);
            step(0, 0, 1);
        end
        step(0, 0, 0);
        step(0, 1, 1);
        repeat (hold - 1) step(0, 1, 0);
        step(0, 0, 0);
    endtask

    initial begin
        int r, gap, rej0;
        ifc.peak = 1'b0;
        ifc.sample_tick = 1'b0;

        do_reset();
        check("rst_bpm", 32'(ifc.bpm), 32'd0);
        check("rst_locked", 32'(ifc.locked), 32'd0);
        check("rst_interval", 32'(ifc.interval), 32'd0);

        repeat (5) beat(60);
        quiet(25);
        check("steady_bpm", 32'(ifc.bpm), 32'd100);
        check("steady_locked", 32'(ifc.locked), 32'd1);
        check("steady_iv", 32'(ifc.interval), 32'd60);

        do_reset();
        beat(10);
        beat(50); beat(60); beat(75); beat(100);
        quiet(25);
        check("mix_bpm", 32'(ifc.bpm), 32'd84);
        check("mix_locked", 32'(ifc.locked), 32'd1);
        beat(50);
        quiet(25);
        check("evict_bpm", 32'(ifc.bpm), 32'd84);

        repeat (4) beat(60);
        quiet(25);
        rej0 = rej_seen;
        beat(10);
        beat(50);
        quiet(25);
        check("spur_rej", 32'(rej_seen - rej0), 32'd1);
        check("spur_iv", 32'(ifc.interval), 32'd60);
        check("spur_bpm", 32'(ifc.bpm), 32'd100);

        repeat (301) step(0, 0, 1);
        check("tmo_bpm", 32'(ifc.bpm), 32'd0);
        check("tmo_locked", 32'(ifc.locked), 32'd0);
        beat(40);
        beat(60);
        quiet(25);
        check("rearm_bpm", 32'(ifc.bpm), 32'd100);
        check("rearm_locked", 32'(ifc.locked), 32'd0);

        beat(60);
        quiet(8);
        step(1, 0, 0);
        check("abort_bpm", 32'(ifc.bpm), 32'd0);
        check("abort_valid", 32'(ifc.bpm_valid), 32'd0);
        check("abort_interval", 32'(ifc.interval), 32'd0);
        step(1, 0, 0);
        quiet(25);

        beat(30);
        beat(60, 5);
        rej0 = rej_seen;
        beat(3, 1, 0);
        quiet(25);
        check("pend_rej", 32'(rej_seen - rej0), 32'd1);
        check("pend_iv", 32'(ifc.interval), 32'd60);

        repeat (60) begin
            r = $urandom_range(99, 0);
            if (r < 15) gap = $urandom_range(29, 5);
            else if (r < 25) gap = $urandom_range(330, 301);
            else gap = $urandom_range(300, 30);
            beat(gap, $urandom_range(5, 1), 1);
            if (r[0]) quiet($urandom_range(20, 0));
        end
        quiet(25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
